ext_pipe: RTL and testbench

Pipelined, parametrised sign/zero-extend unit for the ALU datapath; successor to the single-cycle combinational extender. Adds pre-rotation of the source by whole bytes, an extend-and-add (accumulate) mode, and a two-stage valid/ready pipeline. It sits between operand fetch and the ALU result mux, and sustains one operation per cycle.

---
 rtl/ext_pipe.sv | 86 ++++++++
 tb/tb_ext_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_pipe.sv
// Two-stage valid/ready sign/zero-extend unit with byte pre-rotation and optional accumulate.
// Stage 1 registers the extended field; stage 2 registers the final result and carry.
module ext_pipe #(
  parameter  int DATA_W = 32,
  localparam int ROT_W  = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [ROT_W-1:0]  in_rot,
  input  logic [DATA_W-1:0] in_src,
  input  logic [DATA_W-1:0] in_base,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_carry
);

  localparam int NB = DATA_W / 8;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_ext;
  logic [DATA_W-1:0] s1_base;
  logic              s1_acc;
  logic              s2_valid;
  logic              s1_adv;
  logic              s2_adv;
  logic [7:0]        byte_lo;
  logic [7:0]        byte_hi;
  logic [15:0]       half;
  logic [DATA_W-1:0] ext;
  logic [DATA_W:0]   sum;

  // Only the low 16 bits of the rotated source are ever used, so pick the two
  // byte lanes directly; the modulo keeps rotation wrapping for any byte count.
  always_comb begin
    int lo_idx;
    int hi_idx;
    lo_idx  = int'(in_rot) % NB;
    hi_idx  = (lo_idx + 1) % NB;
    byte_lo = in_src[8*lo_idx +: 8];
    byte_hi = in_src[8*hi_idx +: 8];
    half    = {byte_hi, byte_lo};
    if (in_op[0])
      ext = {{(DATA_W-16){in_op[1] & half[15]}}, half};
    else
      ext = {{(DATA_W-8){in_op[1] & byte_lo[7]}}, byte_lo};
  end

  assign sum       = {1'b0, s1_ext} + {1'b0, s1_base};
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_ext     <= '0;
      s1_base    <= '0;
      s1_acc     <= 1'b0;
      s2_valid   <= 1'b0;
      out_result <= '0;
      out_carry  <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_result <= s1_acc ? sum[DATA_W-1:0] : s1_ext;
          out_carry  <= s1_acc & sum[DATA_W];
        end
      end
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_ext  <= ext;
          s1_base <= in_base;
          s1_acc  <= in_op[2];
        end
      end
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
// Scoreboard bench for ext_pipe: drivers push expected results, per-width monitors pop and compare.
// A 32-bit and a 64-bit instance share clock and reset.
module tb_ext_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_carry;
  logic [2:0]  in_op;
  logic [1:0]  in_rot;
  logic [31:0] in_src, in_base, out_result;
  logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_out_carry;
  logic [2:0]  d_in_op;
  logic [2:0]  d_in_rot;
  logic [63:0] d_in_src, d_in_base, d_out_result;

  always #5 clk = ~clk;

  ext_pipe #(.DATA_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rot(in_rot), .in_src(in_src), .in_base(in_base),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_carry(out_carry)
  );

  ext_pipe #(.DATA_W(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_op(d_in_op), .in_rot(d_in_rot), .in_src(d_in_src), .in_base(d_in_base),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_result(d_out_result), .out_carry(d_out_carry)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_acc    = 0;
  bit          rnd_done = 0;
  logic [64:0] exp32[$];
  logic [64:0] exp64[$];

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: rotate with shifts, extend by masking; result packed as {carry, 64-bit result}.
  function automatic logic [64:0] model(input logic [2:0] op, input int rot,
                                        input logic [63:0] src, input logic [63:0] base, input int w);
    logic [63:0] mask, r, ext;
    logic [64:0] sum;
    mask = (w == 64) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
    r    = ((src >> (8*rot)) | (src << (w - 8*rot))) & mask;
    if (op[0])
      ext = (op[1] && r[15]) ? ((mask & ~64'hFFFF) | {48'b0, r[15:0]}) : {48'b0, r[15:0]};
    else
      ext = (op[1] && r[7]) ? ((mask & ~64'hFF) | {56'b0, r[7:0]}) : {56'b0, r[7:0]};
    if (op[2]) begin
      sum = {1'b0, ext} + {1'b0, base & mask};
      return {sum[w], sum[63:0] & mask};
    end
    return {1'b0, ext};
  endfunction

  logic        h32_v = 1'b0;
  logic [64:0] h32;
  always @(negedge clk) begin
    logic [64:0] got;
    got = {out_carry, 32'b0, out_result};
    if (!rst_n) h32_v = 1'b0;
    else begin
      if (h32_v && out_valid) chk("stall_hold32", got, h32);
      if (out_valid && out_ready) begin
        if (exp32.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected32: got %h, expected no output", got);
        end else chk("result32", got, exp32.pop_front());
      end
      h32_v = out_valid && !out_ready;
      h32   = got;
    end
  end

  logic        h64_v = 1'b0;
  logic [64:0] h64;
  always @(negedge clk) begin
    logic [64:0] got;
    got = {d_out_carry, d_out_result};
    if (!rst_n) h64_v = 1'b0;
    else begin
      if (h64_v && d_out_valid) chk("stall_hold64", got, h64);
      if (d_out_valid && d_out_ready) begin
        if (exp64.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected64: got %h, expected no output", got);
        end else chk("result64", got, exp64.pop_front());
      end
      h64_v = d_out_valid && !d_out_ready;
      h64   = got;
    end
  end

  task automatic drive32(input logic [2:0] op, input int rot, input logic [31:0] src,
                         input logic [31:0] base, input logic [64:0] e);
    bit ok = 0;
    in_op = op; in_rot = rot[1:0]; in_src = src; in_base = base; in_valid = 1'b1;
    for (int t = 0; t < 500 && !ok; t++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (ok) begin exp32.push_back(e); n_acc++; end
    else begin n_checks++; n_fail++; $display("FAIL accept_timeout32: got in_ready stuck low, expected accept"); end
  endtask

  task automatic drive64(input logic [2:0] op, input int rot, input logic [63:0] src,
                         input logic [63:0] base, input logic [64:0] e);
    bit ok = 0;
    d_in_op = op; d_in_rot = rot[2:0]; d_in_src = src; d_in_base = base; d_in_valid = 1'b1;
    for (int t = 0; t < 500 && !ok; t++) begin
      @(negedge clk); ok = d_in_ready;
      @(posedge clk); #1;
    end
    d_in_valid = 1'b0;
    if (ok) exp64.push_back(e);
    else begin n_checks++; n_fail++; $display("FAIL accept_timeout64: got in_ready stuck low, expected accept"); end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 5000 && (exp32.size() != 0 || exp64.size() != 0); t++) @(posedge clk);
    if (exp32.size() != 0 || exp64.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: got %0d/%0d pending, expected 0", exp32.size(), exp64.size());
    end
    #1;
  endtask

  logic [31:0] uxtb_exp [4] = '{32'hBB, 32'hAA, 32'h99, 32'h88};

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_op = 3'b010; in_rot = 2'd0; in_src = 32'h80; in_base = 32'h0;
    d_in_valid = 1'b0; d_out_ready = 1'b1; d_in_op = 3'b0; d_in_rot = 3'd0; d_in_src = '0; d_in_base = '0;
    #12;
    chk("reset_outputs", {out_valid, out_carry, out_result}, '0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_outputs64", {d_out_valid, d_out_carry, d_out_result}, '0);
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;

    // latency: SXTB 0x80 accepted at edge N, visible after edge N+1, sampled at N+2
    drive32(3'b010, 0, 32'h80, 32'h0, {1'b0, 64'hFFFF_FF80});
    chk("latency_not_early", out_valid, 0);
    @(posedge clk); #1;
    chk("latency_valid", out_valid, 1);
    chk("latency_result", out_result, 32'hFFFF_FF80);

    for (int r = 0; r < 4; r++) drive32(3'b000, r, 32'h8899_AABB, 32'h0, {33'b0, uxtb_exp[r]});
    drive32(3'b011, 3, 32'h8899_AABB, 32'h0, {1'b0, 64'hFFFF_BB88});
    drive32(3'b110, 0, 32'h0000_00FF, 32'h0000_0010, {1'b1, 64'h0000_000F});
    drive32(3'b101, 0, 32'h1234_FFFF, 32'hFFFF_0001, {1'b1, 64'h0});
    drive32(3'b100, 1, 32'h0000_7F00, 32'h0000_0001, {1'b0, 64'h80});
    drive32(3'b010, 2, 32'h007F_0000, 32'h0, {1'b0, 64'h7F});
    drive32(3'b001, 3, 32'h8899_AABB, 32'h1234, {1'b0, 64'hBB88});
    wait_drain();

    // back-pressure: two accepts fill the pipe, then in_ready stays low until out_ready rises
    out_ready = 1'b0; n_acc = 0;
    fork
      begin
        drive32(3'b000, 0, 32'h11, 32'h0, {1'b0, 64'h11});
        drive32(3'b000, 0, 32'h22, 32'h0, {1'b0, 64'h22});
        drive32(3'b000, 0, 32'h33, 32'h0, {1'b0, 64'h33});
        drive32(3'b000, 0, 32'h44, 32'h0, {1'b0, 64'h44});
      end
      begin
        repeat (6) @(posedge clk);
        #2;
        chk("bp_accepts", n_acc, 2);
        chk("bp_in_ready_low", in_ready, 0);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_comb", in_ready, 1);
      end
    join
    wait_drain();

    // reset with both stages full: everything in flight is dropped
    out_ready = 1'b0;
    drive32(3'b000, 0, 32'hA1, 32'h0, {1'b0, 64'hA1});
    drive32(3'b000, 0, 32'hA2, 32'h0, {1'b0, 64'hA2});
    chk("mid_full_in_ready", in_ready, 0);
    chk("mid_full_valid", out_valid, 1);
    #2; rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    exp32.delete();
    @(negedge clk); #2; rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_no_output", out_valid, 0);
    drive32(3'b011, 1, 32'h0080_1234, 32'h0, {1'b0, 64'hFFFF_8012});
    wait_drain();

    drive64(3'b011, 7, 64'h8012_3456_789A_BC01, 64'h0, {1'b0, 64'h0000_0000_0000_0180});
    drive64(3'b000, 7, 64'hAB00_0000_0000_0000, 64'h0, {1'b0, 64'hAB});
    drive64(3'b111, 0, 64'h0000_0000_0000_8000, 64'h0000_0000_0000_8000, {1'b1, 64'h0});
    drive64(3'b010, 5, 64'h0000_9000_0000_0000, 64'h0, {1'b0, 64'hFFFF_FFFF_FFFF_FF90});
    wait_drain();

    fork
      begin
        fork
          for (int i = 0; i < 4000; i++) begin
            logic [2:0]  op;
            int          rot;
            logic [31:0] src, base;
            op = 3'($urandom_range(7)); rot = $urandom_range(3);
            src = $urandom; base = $urandom;
            drive32(op, rot, src, base, model(op, rot, {32'b0, src}, {32'b0, base}, 32));
            if ($urandom_range(3) == 0) begin @(posedge clk); #1; end
          end
          for (int i = 0; i < 4000; i++) begin
            logic [2:0]  op;
            int          rot;
            logic [63:0] src, base;
            op = 3'($urandom_range(7)); rot = $urandom_range(7);
            src = {$urandom, $urandom}; base = {$urandom, $urandom};
            drive64(op, rot, src, base, model(op, rot, src, base, 64));
            if ($urandom_range(3) == 0) begin @(posedge clk); #1; end
          end
        join
        rnd_done = 1;
      end
      while (!rnd_done) begin
        @(posedge clk); #1;
        out_ready   = ($urandom_range(3) != 0);
        d_out_ready = ($urandom_range(3) != 0);
      end
    join
    out_ready = 1'b1; d_out_ready = 1'b1;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
